huffman_canon_decoder: RTL and testbench

Parametrised canonical-Huffman bit-serial decoder, the next-generation replacement for the fixed-table 5-bit symbol decoder. Code lengths and the symbol table are programmed at run time, not hard-wired. Bits and symbols move over valid/ready handshakes. Invalid codes are detected explicitly. It sits between the bitstream unpacker (upstream) and the symbol consumer (downstream).

---
 rtl/huffman_pkg.sv | 19 +
 rtl/huffman_canon_decoder_if.sv | 40 ++++
 rtl/huffman_code_table.sv | 46 ++++
 rtl/huffman_canon_decoder.sv | 159 +++++++++++++++
 tb/tb_huffman_canon_decoder.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/huffman_pkg.sv
// Shared defaults, FSM state encoding and length helpers for the canonical Huffman decoder.
package huffman_pkg;

  localparam int DEF_SYM_W   = 5;
  localparam int DEF_MAX_LEN = 8;

  typedef enum logic [1:0] {
    DECODE = 2'd0,
    EMIT   = 2'd1,
    ERR    = 2'd2
  } state_t;

  typedef logic [$clog2(DEF_MAX_LEN + 1)-1:0] len_t;

  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/huffman_canon_decoder_if.sv
// Bit/symbol handshakes, flush and table-programming ports of the canonical Huffman decoder.
interface huffman_canon_decoder_if
  import huffman_pkg::*;
#(
  parameter int SYM_W   = DEF_SYM_W,
  parameter int MAX_LEN = DEF_MAX_LEN
);
  localparam int LEN_W = len_width(MAX_LEN);

  logic             flush;
  logic             cfg_cnt_we;
  logic [LEN_W-1:0] cfg_cnt_len;
  logic [SYM_W:0]   cfg_cnt_data;
  logic             cfg_sym_we;
  logic [SYM_W-1:0] cfg_sym_addr;
  logic [SYM_W-1:0] cfg_sym_data;
  logic             bit_valid;
  logic             bit_ready;
  logic             bit_in;
  logic             sym_valid;
  logic             sym_ready;
  logic [SYM_W-1:0] sym_out;
  logic [LEN_W-1:0] sym_len;
  logic             err;

  modport master (
    output flush, cfg_cnt_we, cfg_cnt_len, cfg_cnt_data,
    output cfg_sym_we, cfg_sym_addr, cfg_sym_data,
    output bit_valid, bit_in, sym_ready,
    input  bit_ready, sym_valid, sym_out, sym_len, err
  );

  modport slave (
    input  flush, cfg_cnt_we, cfg_cnt_len, cfg_cnt_data,
    input  cfg_sym_we, cfg_sym_addr, cfg_sym_data,
    input  bit_valid, bit_in, sym_ready,
    output bit_ready, sym_valid, sym_out, sym_len, err
  );

endinterface

// File: rtl/huffman_code_table.sv
// Programmable per-length code counts and canonical-index symbol RAM with combinational reads.
module huffman_code_table
  import huffman_pkg::*;
#(
  parameter int SYM_W   = DEF_SYM_W,
  parameter int MAX_LEN = DEF_MAX_LEN
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cnt_we,
  input  logic [len_width(MAX_LEN)-1:0] cnt_wlen,
  input  logic [SYM_W:0]                cnt_wdata,
  input  logic                          sym_we,
  input  logic [SYM_W-1:0]              sym_waddr,
  input  logic [SYM_W-1:0]              sym_wdata,
  input  logic [len_width(MAX_LEN)-1:0] cnt_rlen,
  output logic [SYM_W:0]                cnt_rdata,
  input  logic [SYM_W-1:0]              sym_raddr,
  output logic [SYM_W-1:0]              sym_rdata
);

  logic [SYM_W:0]   cnt_r [0:MAX_LEN];
  logic [SYM_W-1:0] sym_r [0:(2**SYM_W)-1];

  // Count registers; entry 0 is never written, so length 0 always reads as "no codes".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= MAX_LEN; i++) cnt_r[i] <= '0;
    end else if (cnt_we && (cnt_wlen != '0) && (32'(cnt_wlen) <= 32'(MAX_LEN))) begin
      cnt_r[cnt_wlen] <= cnt_wdata;
    end
  end

  // Symbol RAM indexed by canonical position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < (2**SYM_W); i++) sym_r[i] <= '0;
    end else if (sym_we) begin
      sym_r[sym_waddr] <= sym_wdata;
    end
  end

  assign cnt_rdata = (32'(cnt_rlen) <= 32'(MAX_LEN)) ? cnt_r[cnt_rlen] : '0;
  assign sym_rdata = sym_r[sym_raddr];

endmodule

// File: rtl/huffman_canon_decoder.sv
// Bit-serial canonical Huffman decoder with run-time programmable tables.
// Optional HUFF_STICKY_ERR_EN: an invalid code parks the block in ERR until flush or rst.
module huffman_canon_decoder
  import huffman_pkg::*;
#(
  parameter int SYM_W   = DEF_SYM_W,
  parameter int MAX_LEN = DEF_MAX_LEN
) (
  input logic                    clk,
  input logic                    rst,
  huffman_canon_decoder_if.slave bus
);

  localparam int LEN_W = len_width(MAX_LEN);
  localparam int CW    = MAX_LEN + 1;

  state_t             state_r, state_nx;
  logic [MAX_LEN-1:0] code_r, code_nx;
  logic [MAX_LEN-1:0] first_r, first_nx;
  logic [SYM_W:0]     index_r, index_nx;
  logic [LEN_W-1:0]   len_r, len_nx;
  logic [SYM_W-1:0]   sym_out_r, sym_out_nx;
  logic [LEN_W-1:0]   sym_len_r, sym_len_nx;
  logic               err_r, err_nx;

  logic [LEN_W-1:0]   len_s;
  logic [CW-1:0]      code_ext_s;
  logic [CW-1:0]      diff_s;
  logic [SYM_W:0]     cnt_rd_s;
  logic [SYM_W-1:0]   sym_addr_s;
  logic [SYM_W-1:0]   sym_rd_s;
  logic               match_s;
  logic               last_s;
  logic               bit_ready_s;
  logic               bit_fire_s;

  huffman_code_table #(
    .SYM_W   (SYM_W),
    .MAX_LEN (MAX_LEN)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .cnt_we    (bus.cfg_cnt_we),
    .cnt_wlen  (bus.cfg_cnt_len),
    .cnt_wdata (bus.cfg_cnt_data),
    .sym_we    (bus.cfg_sym_we),
    .sym_waddr (bus.cfg_sym_addr),
    .sym_wdata (bus.cfg_sym_data),
    .cnt_rlen  (len_s),
    .cnt_rdata (cnt_rd_s),
    .sym_raddr (sym_addr_s),
    .sym_rdata (sym_rd_s)
  );

  // A wrapped difference (code below first) is huge and can never match.
  assign len_s      = len_r + LEN_W'(1);
  assign code_ext_s = {code_r, bus.bit_in};
  assign diff_s     = code_ext_s - {1'b0, first_r};
  assign match_s    = (32'(diff_s) < 32'(cnt_rd_s));
  assign last_s     = (32'(len_s) == 32'(MAX_LEN));
  assign sym_addr_s = SYM_W'(32'(index_r) + 32'(diff_s));
  assign bit_fire_s = bus.bit_valid && bit_ready_s;

  // Bit acceptance: free-running in DECODE, follows the consumer in EMIT.
  always_comb begin
    bit_ready_s = 1'b0;
    case (state_r)
      DECODE:  bit_ready_s = 1'b1;
      EMIT:    bit_ready_s = bus.sym_ready;
      default: bit_ready_s = 1'b0;
    endcase
  end

  // Next-state, accumulator and output-register update.
  always_comb begin
    state_nx   = state_r;
    code_nx    = code_r;
    first_nx   = first_r;
    index_nx   = index_r;
    len_nx     = len_r;
    sym_out_nx = sym_out_r;
    sym_len_nx = sym_len_r;
    err_nx     = 1'b0;
    if (bus.flush) begin
      state_nx = DECODE;
      code_nx  = '0;
      first_nx = '0;
      index_nx = '0;
      len_nx   = '0;
    end else begin
      if ((state_r == EMIT) && bus.sym_ready) begin
        state_nx = DECODE;
      end else begin
        state_nx = state_r;
      end
      if (bit_fire_s) begin
        if (match_s) begin
          state_nx   = EMIT;
          sym_out_nx = sym_rd_s;
          sym_len_nx = len_s;
          code_nx    = '0;
          first_nx   = '0;
          index_nx   = '0;
          len_nx     = '0;
        end else if (last_s) begin
          code_nx  = '0;
          first_nx = '0;
          index_nx = '0;
          len_nx   = '0;
          err_nx   = 1'b1;
`ifdef HUFF_STICKY_ERR_EN
          state_nx = ERR;
`endif
        end else begin
          code_nx  = code_ext_s[MAX_LEN-1:0];
          first_nx = MAX_LEN'((32'(first_r) + 32'(cnt_rd_s)) << 1);
          index_nx = index_r + cnt_rd_s;
          len_nx   = len_s;
        end
      end else begin
`ifdef HUFF_STICKY_ERR_EN
        err_nx = (state_r == ERR);
`else
        err_nx = 1'b0;
`endif
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= DECODE;
      code_r    <= '0;
      first_r   <= '0;
      index_r   <= '0;
      len_r     <= '0;
      sym_out_r <= '0;
      sym_len_r <= '0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_nx;
      code_r    <= code_nx;
      first_r   <= first_nx;
      index_r   <= index_nx;
      len_r     <= len_nx;
      sym_out_r <= sym_out_nx;
      sym_len_r <= sym_len_nx;
      err_r     <= err_nx;
    end
  end

  assign bus.bit_ready = bit_ready_s;
  assign bus.sym_valid = (state_r == EMIT);
  assign bus.sym_out   = sym_out_r;
  assign bus.sym_len   = sym_len_r;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_huffman_canon_decoder.sv
// Directed self-checking bench for huffman_canon_decoder (default parameters, table T1).
module tb_huffman_canon_decoder;
  import huffman_pkg::*;

  localparam int SYM_W   = DEF_SYM_W;
  localparam int MAX_LEN = DEF_MAX_LEN;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  huffman_canon_decoder_if #(.SYM_W(SYM_W), .MAX_LEN(MAX_LEN)) bus ();

  huffman_canon_decoder #(
    .SYM_W   (SYM_W),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr_cnt(input int len, input int data);
    bus.cfg_cnt_we   = 1'b1;
    bus.cfg_cnt_len  = len_t'(len);
    bus.cfg_cnt_data = (SYM_W+1)'(data);
    @(negedge clk);
    bus.cfg_cnt_we   = 1'b0;
  endtask

  task automatic wr_sym(input int addr, input int data);
    bus.cfg_sym_we   = 1'b1;
    bus.cfg_sym_addr = SYM_W'(addr);
    bus.cfg_sym_data = SYM_W'(data);
    @(negedge clk);
    bus.cfg_sym_we   = 1'b0;
  endtask

  task automatic load_t1();
    int syms [8];
    syms = '{3, 7, 1, 9, 20, 21, 22, 23};
    wr_cnt(1, 0);
    wr_cnt(2, 2);
    wr_cnt(3, 2);
    wr_cnt(4, 4);
    for (int i = 0; i < 8; i++) wr_sym(i, syms[i]);
  endtask

  task automatic send(input logic b);
    bus.bit_valid = 1'b1;
    bus.bit_in    = b;
    @(negedge clk);
    bus.bit_valid = 1'b0;
  endtask

  initial begin
    int s2 [7];
    s2 = '{1, 0, 1, 1, 1, 1, 1};
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.cfg_cnt_we = 1'b0; bus.cfg_cnt_len = '0; bus.cfg_cnt_data = '0;
    bus.cfg_sym_we = 1'b0; bus.cfg_sym_addr = '0; bus.cfg_sym_data = '0;
    bus.bit_valid = 1'b0; bus.bit_in = 1'b0; bus.sym_ready = 1'b1;

    // Reset values
    @(negedge clk);
    chk("rst_sym_valid", 32'(bus.sym_valid), 32'd0);
    chk("rst_sym_out",   32'(bus.sym_out),   32'd0);
    chk("rst_sym_len",   32'(bus.sym_len),   32'd0);
    chk("rst_err",       32'(bus.err),       32'd0);
    chk("rst_bit_ready", 32'(bus.bit_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    load_t1();

    // Bits 0,1 -> 7 (len 2), valid the cycle after the 2nd bit
    send(1'b0);
    chk("s1_not_yet", 32'(bus.sym_valid), 32'd0);
    send(1'b1);
    chk("s1_valid", 32'(bus.sym_valid), 32'd1);
    chk("s1_sym",   32'(bus.sym_out),   32'd7);
    chk("s1_len",   32'(bus.sym_len),   32'd2);
    @(negedge clk);
    chk("s1_consumed", 32'(bus.sym_valid), 32'd0);

    // Bits 1,0,1,1,1,1,1 streamed back-to-back -> 9 then 23
    for (int i = 0; i < 7; i++) begin
      bus.bit_in = s2[i];
      bus.bit_valid = 1'b1;
      #1;
      chk("s2_bit_ready", 32'(bus.bit_ready), 32'd1);
      if (i == 3) begin
        chk("s2_valid9", 32'(bus.sym_valid), 32'd1);
        chk("s2_sym9",   32'(bus.sym_out),   32'd9);
        chk("s2_len9",   32'(bus.sym_len),   32'd3);
      end
      if (i == 4) chk("s2_gap", 32'(bus.sym_valid), 32'd0);
      @(negedge clk);
    end
    bus.bit_valid = 1'b0;
    chk("s2_valid23", 32'(bus.sym_valid), 32'd1);
    chk("s2_sym23",   32'(bus.sym_out),   32'd23);
    chk("s2_len23",   32'(bus.sym_len),   32'd4);
    @(negedge clk);
    chk("s2_done", 32'(bus.sym_valid), 32'd0);

    // Bits 0,0 with 3 cycles of back-pressure -> 3 held
    bus.sym_ready = 1'b0;
    send(1'b0);
    send(1'b0);
    bus.bit_valid = 1'b1;
    bus.bit_in = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("s3_bit_ready_low", 32'(bus.bit_ready), 32'd0);
      chk("s3_hold_valid",    32'(bus.sym_valid), 32'd1);
      chk("s3_hold_sym",      32'(bus.sym_out),   32'd3);
      chk("s3_hold_len",      32'(bus.sym_len),   32'd2);
      @(negedge clk);
    end
    bus.bit_valid = 1'b0;
    bus.sym_ready = 1'b1;
    #1;
    chk("s3_bit_ready_comb", 32'(bus.bit_ready), 32'd1);
    @(negedge clk);
    chk("s3_one_transfer", 32'(bus.sym_valid), 32'd0);

    // Flush drops a pending symbol
    bus.sym_ready = 1'b0;
    send(1'b0);
    send(1'b1);
    chk("fd_pending", 32'(bus.sym_out), 32'd7);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.sym_ready = 1'b1;
    chk("fd_dropped", 32'(bus.sym_valid), 32'd0);

    // cnt1=1, sym[0]=5; eight one-bits form an invalid code
    bus.flush = 1'b1;
    wr_cnt(1, 1);
    wr_cnt(2, 0);
    wr_cnt(3, 0);
    wr_cnt(4, 0);
    wr_sym(0, 5);
    bus.flush = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("s4_err_quiet", 32'(bus.err), 32'd0);
      send(1'b1);
    end
    chk("s4_err_set",   32'(bus.err),       32'd1);
    chk("s4_no_symbol", 32'(bus.sym_valid), 32'd0);
`ifdef HUFF_STICKY_ERR_EN
    #1;
    chk("s4_stuck_ready", 32'(bus.bit_ready), 32'd0);
    send(1'b0);
    chk("s4_err_held",  32'(bus.err),       32'd1);
    chk("s4_no_decode", 32'(bus.sym_valid), 32'd0);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("s4_flush_err", 32'(bus.err), 32'd0);
    #1;
    chk("s4_flush_ready", 32'(bus.bit_ready), 32'd1);
    send(1'b0);
`else
    send(1'b0);
    chk("s4_err_pulse", 32'(bus.err), 32'd0);
`endif
    chk("s4_valid5", 32'(bus.sym_valid), 32'd1);
    chk("s4_sym5",   32'(bus.sym_out),   32'd5);
    chk("s4_len1",   32'(bus.sym_len),   32'd1);
    @(negedge clk);
    load_t1();

    // Bits 1,1, flush (a bit offered alongside is discarded), bits 0,0 -> only 3
    send(1'b1);
    send(1'b1);
    chk("s5_partial", 32'(bus.sym_valid), 32'd0);
    bus.flush = 1'b1;
    bus.bit_valid = 1'b1;
    bus.bit_in = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.bit_valid = 1'b0;
    send(1'b0);
    chk("s5_no_early", 32'(bus.sym_valid), 32'd0);
    send(1'b0);
    chk("s5_valid", 32'(bus.sym_valid), 32'd1);
    chk("s5_sym3",  32'(bus.sym_out),   32'd3);
    @(negedge clk);
    chk("s5_only_one", 32'(bus.sym_valid), 32'd0);

    // Asynchronous reset mid-code, then tables read back as empty
    send(1'b1);
    bus.bit_valid = 1'b1;
    bus.bit_in = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("s6_sym_valid", 32'(bus.sym_valid), 32'd0);
    chk("s6_sym_out",   32'(bus.sym_out),   32'd0);
    chk("s6_sym_len",   32'(bus.sym_len),   32'd0);
    chk("s6_err",       32'(bus.err),       32'd0);
    chk("s6_bit_ready", 32'(bus.bit_ready), 32'd1);
    @(negedge clk);
    bus.bit_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(1'b0);
      chk("s6_empty_table", 32'(bus.sym_valid), 32'd0);
    end
    chk("s6_all_invalid", 32'(bus.err), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
